// File: rtl/xadc_drp_scheduler.sv
// DRP read sequencer for the XADC wizard: scans the Pmod analog channels after each
// end-of-conversion into a cache, and serves single host reads in between scan reads.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | arbitrate: host read, next scan read, or start a pending scan
//   S_ISSUE | drp_den high for this one cycle, drp_daddr valid
//   S_WAIT  | wait for drp_drdy, abort after TIMEOUT cycles
module xadc_drp_scheduler #(
  parameter int NUM_CH  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK100MHZ,
  input  logic        reset_in,
  input  logic        eoc_in,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic        host_req,
  input  logic [6:0]  host_addr,
  output logic        host_ack,
  output logic [15:0] host_data,
  input  logic [3:0]  ch_sel,
  output logic [11:0] ch_value,
  output logic        sample_valid,
  output logic [3:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        timeout_err
);

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LP_LAST_CH  = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           r_state;
  logic             r_owner_host;
  logic             r_scan_pending;
  logic             r_scan_active;
  logic [3:0]       r_scan_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_daddr;
  logic             r_den;
  logic             r_host_ack;
  logic [15:0]      r_host_data;
  logic             r_sample_valid;
  logic [3:0]       r_sample_ch;
  logic [11:0]      r_sample_data;
  logic             r_timeout_err;
  logic [11:0]      r_ch_value;
  logic [11:0]      r_cache [NUM_CH];

  logic             w_scan_last;
  logic             w_ch_in_range;

  assign w_scan_last   = (r_scan_idx == LP_LAST_CH);
  assign w_ch_in_range = (ch_sel <= LP_LAST_CH);

  function automatic logic [6:0] f_scan_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    f_scan_addr = 7'h14;
      4'd1:    f_scan_addr = 7'h15;
      4'd2:    f_scan_addr = 7'h16;
      4'd3:    f_scan_addr = 7'h17;
      4'd4:    f_scan_addr = 7'h1F;
      4'd5:    f_scan_addr = 7'h10;
      4'd6:    f_scan_addr = 7'h1C;
      4'd7:    f_scan_addr = 7'h1D;
      4'd8:    f_scan_addr = 7'h1E;
      default: f_scan_addr = 7'h14;
    endcase
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      r_state        <= S_IDLE;
      r_owner_host   <= 1'b0;
      r_scan_pending <= 1'b0;
      r_scan_active  <= 1'b0;
      r_scan_idx     <= '0;
      r_cnt          <= '0;
      r_daddr        <= '0;
      r_den          <= 1'b0;
      r_host_ack     <= 1'b0;
      r_host_data    <= '0;
      r_sample_valid <= 1'b0;
      r_sample_ch    <= '0;
      r_sample_data  <= '0;
      r_timeout_err  <= 1'b0;
      r_ch_value     <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cache[i] <= '0;
    end else begin
      r_den          <= 1'b0;
      r_host_ack     <= 1'b0;
      r_sample_valid <= 1'b0;
      r_ch_value     <= w_ch_in_range ? r_cache[ch_sel] : '0;

      case (r_state)
        S_IDLE: begin
          // During the ack cycle the host may still be holding host_req for the read just served.
          if (host_req && !r_host_ack) begin
            r_owner_host <= 1'b1;
            r_daddr      <= host_addr;
            r_den        <= 1'b1;
            r_state      <= S_ISSUE;
          end else if (r_scan_active) begin
            r_owner_host <= 1'b0;
            r_daddr      <= f_scan_addr(r_scan_idx);
            r_den        <= 1'b1;
            r_state      <= S_ISSUE;
          end else if (r_scan_pending) begin
            r_scan_pending <= 1'b0;
            r_scan_active  <= 1'b1;
            r_scan_idx     <= '0;
          end
        end

        S_ISSUE: begin
          r_cnt   <= LP_CNT_LOAD;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (drp_drdy) begin
            r_state <= S_IDLE;
            if (r_owner_host) begin
              r_host_ack  <= 1'b1;
              r_host_data <= drp_do;
            end else begin
              r_cache[r_scan_idx] <= drp_do[15:4];
              r_sample_valid      <= 1'b1;
              r_sample_ch         <= r_scan_idx;
              r_sample_data       <= drp_do[15:4];
              if (w_scan_last) r_scan_active <= 1'b0;
              else             r_scan_idx    <= r_scan_idx + 4'd1;
            end
          end else if (r_cnt == '0) begin
            r_state       <= S_IDLE;
            r_timeout_err <= 1'b1;
            if (r_owner_host) begin
              r_host_ack  <= 1'b1;
              r_host_data <= '0;
            end else if (w_scan_last) begin
              r_scan_active <= 1'b0;
            end else begin
              r_scan_idx <= r_scan_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Placed last so an eoc in the same cycle a pending scan starts re-arms it.
      if (eoc_in) r_scan_pending <= 1'b1;
    end
  end

  assign drp_daddr    = r_daddr;
  assign drp_den      = r_den;
  assign drp_dwe      = 1'b0;
  assign drp_di       = 16'h0000;
  assign host_ack     = r_host_ack;
  assign host_data    = r_host_data;
  assign ch_value     = r_ch_value;
  assign sample_valid = r_sample_valid;
  assign sample_ch    = r_sample_ch;
  assign sample_data  = r_sample_data;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Scoreboard bench for xadc_drp_scheduler: a DRP model answers reads, stimulus pushes
// expected reads/samples/acks into queues, a monitor pops and compares them.
module tb_xadc_drp_scheduler;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        eoc_in = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_drdy = 1'b0;
  logic        host_req = 1'b0;
  logic [6:0]  host_addr = 7'h00;
  logic        host_ack;
  logic [15:0] host_data;
  logic [3:0]  ch_sel = 4'd0;
  logic [11:0] ch_value;
  logic        sample_valid;
  logic [3:0]  sample_ch;
  logic [11:0] sample_data;
  logic        timeout_err;

  always #5 clk = ~clk;

  xadc_drp_scheduler dut (
    .CLK100MHZ    (clk),
    .reset_in     (reset_in),
    .eoc_in       (eoc_in),
    .drp_daddr    (drp_daddr),
    .drp_den      (drp_den),
    .drp_dwe      (drp_dwe),
    .drp_di       (drp_di),
    .drp_do       (drp_do),
    .drp_drdy     (drp_drdy),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_ack     (host_ack),
    .host_data    (host_data),
    .ch_sel       (ch_sel),
    .ch_value     (ch_value),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .timeout_err  (timeout_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int den_cnt = 0;
  int smp_cnt = 0;

  logic [6:0]  exp_den_q  [$];
  logic [15:0] exp_smp_q  [$];
  logic [15:0] exp_host_q [$];

  logic [6:0] scan_tab [9] = '{7'h14, 7'h15, 7'h16, 7'h17, 7'h1F, 7'h10, 7'h1C, 7'h1D, 7'h1E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // DRP model: drdy 3 cycles after den, data {channel index, 12'hA50}; unknown addresses read 0xBEEF.
  int          drdy_cd = -1;
  logic [15:0] resp_data = 16'h0000;
  int          withhold_idx = -1;
  bit          late_armed = 1'b0;

  always @(posedge clk) begin
    int idx;
    #1;
    drp_drdy = 1'b0;
    if (late_armed && timeout_err) begin
      drp_drdy   = 1'b1;
      drp_do     = 16'hFFFF;
      late_armed = 1'b0;
    end
    if (drdy_cd == 0) begin
      drp_drdy = 1'b1;
      drp_do   = resp_data;
    end
    if (drdy_cd >= 0) drdy_cd--;
    if (drp_den) begin
      idx = -1;
      for (int i = 0; i < 9; i++) if (scan_tab[i] == drp_daddr) idx = i;
      if (idx >= 0 && idx == withhold_idx) begin
        late_armed = 1'b1;
      end else begin
        resp_data = (idx >= 0) ? {4'(idx), 12'hA50} : 16'hBEEF;
        drdy_cd   = 2;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a read, sample or ack.
  always @(posedge clk) begin
    logic [6:0]  e_den;
    logic [15:0] e_smp;
    logic [15:0] e_host;
    #1;
    if (drp_den) begin
      den_cnt++;
      check("den_no_write", {15'd0, drp_dwe, drp_di}, 32'd0);
      if (exp_den_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL den_extra: got read at 0x%0h, expected no read", drp_daddr);
      end else begin
        e_den = exp_den_q.pop_front();
        check("den_addr", 32'(drp_daddr), 32'(e_den));
      end
    end
    if (sample_valid) begin
      smp_cnt++;
      if (exp_smp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sample_extra: got ch %0d data 0x%0h, expected no sample", sample_ch, sample_data);
      end else begin
        e_smp = exp_smp_q.pop_front();
        check("sample_ch_data", {16'd0, sample_ch, sample_data}, {16'd0, e_smp});
      end
    end
    if (host_ack) begin
      if (exp_host_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL host_ack_extra: got data 0x%0h, expected no ack", host_data);
      end else begin
        e_host = exp_host_q.pop_front();
        check("host_data", 32'(host_data), 32'(e_host));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_eoc();
    eoc_in = 1'b1;
    tick(1);
    eoc_in = 1'b0;
  endtask

  task automatic wait_addr(input logic [6:0] a, input int budget);
    int n = 0;
    while (!(drp_den && drp_daddr == a) && n < budget) begin tick(1); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_den_0x%0h: got no read within %0d cycles, expected one", a, budget);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_den_q.size() + exp_smp_q.size() + exp_host_q.size()) != 0 && n < budget) begin
      tick(1); n++;
    end
    tick(8);
    check({name, "_den_left"},  32'(exp_den_q.size()),  32'd0);
    check({name, "_smp_left"},  32'(exp_smp_q.size()),  32'd0);
    check({name, "_host_left"}, 32'(exp_host_q.size()), 32'd0);
  endtask

  task automatic push_scan(input int skip);
    for (int i = 0; i < 9; i++) begin
      exp_den_q.push_back(scan_tab[i]);
      if (i != skip) exp_smp_q.push_back({4'(i), 4'(i), 8'hA5});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, t0;
    tick(4);
    reset_in = 1'b0;
    check("rst_den", 32'(drp_den), 0);
    check("rst_daddr", 32'(drp_daddr), 0);
    check("rst_host_ack", 32'(host_ack), 0);
    check("rst_host_data", 32'(host_data), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_ch_value", 32'(ch_value), 0);

    // Single scan
    push_scan(-1);
    pulse_eoc();
    wait_done("scan1", 200);
    check("scan1_den_count", 32'(den_cnt), 32'd9);
    check("scan1_smp_count", 32'(smp_cnt), 32'd9);
    ch_sel = 4'd2;
    tick(1);
    check("ch_value_2", 32'(ch_value), 32'h2A5);

    // Out-of-range and last-index lookups with a full cache
    ch_sel = 4'd12; tick(1); check("ch_value_12", 32'(ch_value), 0);
    ch_sel = 4'd9;  tick(1); check("ch_value_9", 32'(ch_value), 0);
    ch_sel = 4'd8;  tick(1); check("ch_value_8", 32'(ch_value), 32'h8A5);

    // Host read slotted in after channel 4
    for (int i = 0; i < 5; i++) exp_den_q.push_back(scan_tab[i]);
    exp_den_q.push_back(7'h00);
    for (int i = 5; i < 9; i++) exp_den_q.push_back(scan_tab[i]);
    for (int i = 0; i < 9; i++) exp_smp_q.push_back({4'(i), 4'(i), 8'hA5});
    exp_host_q.push_back(16'hBEEF);
    pulse_eoc();
    wait_addr(7'h1F, 100);
    tick(1);
    host_addr = 7'h00;
    host_req  = 1'b1;
    for (int n = 0; n < 50 && !host_ack; n++) tick(1);
    check("host_ack_seen", 32'(host_ack), 1);
    host_req = 1'b0;
    wait_done("host", 200);

    // Coalesced eocs: one extra scan only
    d0 = den_cnt;
    push_scan(-1);
    push_scan(-1);
    pulse_eoc();
    wait_addr(7'h15, 50); pulse_eoc();
    wait_addr(7'h1F, 50); pulse_eoc();
    wait_addr(7'h1C, 50); pulse_eoc();
    wait_done("coalesce", 300);
    tick(30);
    check("coalesce_den_count", 32'(den_cnt - d0), 32'd18);
    check("coalesce_idle_den", 32'(drp_den), 0);

    // Channel 3 withheld: timeout after 255 WAIT cycles
    withhold_idx = 3;
    s0 = smp_cnt;
    push_scan(3);
    pulse_eoc();
    wait_addr(7'h17, 50);
    t0 = cyc;
    check("pre_timeout_err", 32'(timeout_err), 0);
    wait_addr(7'h1F, 400);
    check("timeout_den_gap", 32'(cyc - t0), 32'd257);
    check("timeout_err_set", 32'(timeout_err), 1);
    wait_done("timeout", 200);
    withhold_idx = -1;
    check("timeout_smp_count", 32'(smp_cnt - s0), 32'd8);
    ch_sel = 4'd3; tick(2); check("cache3_kept", 32'(ch_value), 32'h3A5);
    ch_sel = 4'd4; tick(2); check("cache4_after_late", 32'(ch_value), 32'h4A5);

    // Reset while waiting on channel 5
    for (int i = 0; i < 6; i++) exp_den_q.push_back(scan_tab[i]);
    for (int i = 0; i < 5; i++) exp_smp_q.push_back({4'(i), 4'(i), 8'hA5});
    pulse_eoc();
    wait_addr(7'h10, 100);
    tick(1);
    reset_in = 1'b1;
    tick(1);
    reset_in = 1'b0;
    check("mid_rst_den", 32'(drp_den), 0);
    check("mid_rst_daddr", 32'(drp_daddr), 0);
    check("mid_rst_host_data", 32'(host_data), 0);
    check("mid_rst_sample_ch", 32'(sample_ch), 0);
    check("mid_rst_sample_data", 32'(sample_data), 0);
    check("mid_rst_timeout_err", 32'(timeout_err), 0);
    check("mid_rst_ch_value", 32'(ch_value), 0);
    s0 = smp_cnt;
    d0 = den_cnt;
    wait_done("reset", 50);
    tick(10);
    check("reset_no_strobe", 32'(smp_cnt - s0), 0);
    check("reset_no_den", 32'(den_cnt - d0), 0);
    check("reset_cache4_cleared", 32'(ch_value), 0);
    ch_sel = 4'd2; tick(2); check("reset_cache2_cleared", 32'(ch_value), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xadc_drp_scheduler.md
Name: xadc_drp_scheduler

Overview:
- Sequences DRP reads of the XADC wizard so the rest of the design never drives the DRP directly.
- Each XADC end-of-conversion triggers a scan of all nine Pmod analog channels. Results go into a per-channel cache, and each stored sample is announced with a strobe.
- A single host requester can also issue arbitrary DRP reads (e.g. on-chip temperature, address 0x00). The block arbitrates between the host and the scan.
- Sits between the xadc_wiz_0 DRP port and the display/switch logic.

Parameters:
- NUM_CH, 9, number of scanned channels (scan table entries 0..NUM_CH-1).
- TIMEOUT, 255, WAIT-state cycles without drp_drdy before a read is aborted.

Ports:
- CLK100MHZ  in  1  system and DRP clock.
- reset_in  in  1  synchronous, active-high reset.
- eoc_in  in  1  XADC eoc_out, single-cycle pulse.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, one-cycle pulse per read.
- drp_dwe  out  1  DRP write enable, tied 0.
- drp_di  out  16  DRP write data, tied 0.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP data ready.
- host_req  in  1  host read request, level, held until host_ack.
- host_addr  in  7  host DRP address, stable while host_req=1.
- host_ack  out  1  one-cycle completion pulse.
- host_data  out  16  host read result, valid with host_ack and held until the next ack.
- ch_sel  in  4  cache lookup index.
- ch_value  out  12  cached code for ch_sel, registered.
- sample_valid  out  1  one-cycle strobe per stored scan sample.
- sample_ch  out  4  channel index of the sample.
- sample_data  out  12  drp_do[15:4] of the sample.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Scan table, index to address: 0→0x14, 1→0x15, 2→0x16, 3→0x17, 4→0x1F, 5→0x10, 6→0x1C, 7→0x1D, 8→0x1E.
- Reset (synchronous, takes precedence over all activity including a read in flight):
  - State IDLE; scan_pending=0, scan_active=0, scan_idx=0.
  - All outputs 0; all cache entries 0.
  - A drp_drdy arriving after reset is ignored.
- eoc_in=1 sets scan_pending. Pending requests coalesce to a single pending scan. An eoc during an active scan re-arms scan_pending, so one further scan runs afterwards.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration evaluated every cycle, highest priority first:
  - host_req=1 → latch host_addr, owner=HOST, go to ISSUE.
  - else scan_active=1 → owner=SCAN, address = table[scan_idx], go to ISSUE.
  - else scan_pending=1 → scan_pending=0, scan_active=1, scan_idx=0, stay IDLE; the first read issues on the next cycle.
  - The host is served between scan reads and never preempts a read in flight.
- ISSUE: drive drp_den=1 for exactly one cycle with drp_daddr valid, clear the WAIT counter, go to WAIT. drp_daddr holds its value until the next ISSUE.
- WAIT: drp_drdy is sampled only in this state; drdy in any other state is ignored.
  - drdy=1 with owner SCAN: cache[scan_idx] ← drp_do[15:4]. In the next cycle, sample_valid=1, sample_ch=scan_idx, sample_data=drp_do[15:4].
  - drdy=1 with owner HOST: in the next cycle, host_ack=1 and host_data=drp_do.
  - After a drdy, go to IDLE. For SCAN: if scan_idx=NUM_CH-1 then scan_active=0, else scan_idx+1.
  - Counter reaches TIMEOUT with drdy still 0: set timeout_err, go to IDLE.
    - SCAN: the channel is skipped (no cache write, no strobe) and scan_idx advances as for a completed read.
    - HOST: host_ack=1 with host_data=0x0000.
  - drdy and TIMEOUT in the same cycle: drdy wins, no error.
- Latency:
  - Host read: ISSUE is 1 cycle after the request is accepted in IDLE; host_ack is 1 cycle after drdy.
  - Minimum scan-read period: IDLE + ISSUE + (drdy latency) + 1 cycle.
- ch_value is registered:
  - ch_value = cache[ch_sel] one cycle after ch_sel changes or the addressed entry is written.
  - ch_sel ≥ NUM_CH gives 0.
- drp_dwe and drp_di are always 0; the block never writes the DRP.

Test Plan:
- After reset, pulse eoc_in once; the DRP model returns drdy 3 cycles after den with data {idx,12'hA50}. Required: 9 den pulses at addresses 0x14,0x15,0x16,0x17,0x1F,0x10,0x1C,0x1D,0x1E in order, and 9 sample_valid pulses with sample_ch 0..8. Then ch_sel=2 gives ch_value=0x2A5 one cycle later.
- Raise host_req with host_addr=0x00 mid-scan, while scan_idx=4 is in WAIT. Required: channel 4 completes first; the next den uses address 0x00; host_ack=1 with host_data equal to the model data; the scan then resumes at 0x10.
- Pulse eoc_in three times during one scan. Required: exactly one additional full scan (18 den total), then idle with drp_den=0.
- Model withholds drdy for channel 3. Required: after 255 WAIT cycles, timeout_err=1, no sample_valid for channel 3, cache[3] unchanged, and the next den uses 0x1F. A late drdy while in IDLE is ignored.
- Assert reset_in while in WAIT for channel 5. Required: all outputs 0, cache cleared, state IDLE; a late drdy produces no strobe.
- ch_sel=12. Required: ch_value=0 regardless of cache contents.
